rv32i_instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory writer. It accepts instruction descriptors (class, register fields, funct bits, signed immediate) over a valid/ready handshake. It packs each descriptor into the 32-bit word format that the main decoder and immediate extender consume, then writes the word into instruction memory at consecutive word addresses. It sits in the bench/boot path ahead of the single-cycle core's instruction memory and produces exactly the opcode set the core decodes.

---
 rtl/rv32i_enc_pkg.sv | 38 +++
 rtl/rv32i_imm_pack.sv | 70 +++++++
 rtl/rv32i_instr_encoder.sv | 148 ++++++++++++++
 tb/tb_rv32i_instr_encoder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: descriptor class codes,
// opcodes, fixed funct3 values, FSM state type and immediate range helpers.
package rv32i_enc_pkg;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_RTYPE  = 3'd2;
  localparam logic [2:0] CLS_ITYPE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } enc_state_e;

  // A 21-bit value fits N signed bits when all bits above N-1 copy the sign.
  function automatic logic fits_s12(input logic [20:0] v);
    return (&v[20:11]) | (~|v[20:11]);
  endfunction

  function automatic logic fits_s13(input logic [20:0] v);
    return (&v[20:12]) | (~|v[20:12]);
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Inverse of the core's immediate extender: scatters a signed immediate into
// its instruction-word bit positions and flags whether it is encodable.
// JAL support is enabled by defining RV32I_ENC_JAL_EN.
module rv32i_imm_pack
  import rv32i_enc_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic [20:0] imm,
  output logic [31:0] imm_field,
  output logic        class_ok,
  output logic        range_ok
);

  // Per-class immediate placement and legality.
  always_comb begin
    imm_field = 32'h0000_0000;
    class_ok  = 1'b0;
    range_ok  = 1'b0;
    case (cls)
      CLS_LOAD: begin
        imm_field = {imm[11:0], 20'h00000};
        class_ok  = 1'b1;
        range_ok  = fits_s12(imm);
      end
      CLS_STORE: begin
        imm_field = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
        class_ok  = 1'b1;
        range_ok  = fits_s12(imm);
      end
      CLS_RTYPE: begin
        class_ok = 1'b1;
        range_ok = 1'b1;
      end
      CLS_ITYPE: begin
        class_ok = 1'b1;
        // Shifts carry only shamt here; bit 30 is inserted by the caller.
        if (funct3 == F3_SRX) begin
          imm_field = {7'h00, imm[4:0], 20'h00000};
          range_ok  = fits_s12(imm) & (imm[11:5] == 7'h00);
        end else begin
          imm_field = {imm[11:0], 20'h00000};
          range_ok  = fits_s12(imm);
        end
      end
      CLS_BRANCH: begin
        imm_field = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
        class_ok  = 1'b1;
        range_ok  = fits_s13(imm) & ~imm[0];
      end
      CLS_JAL: begin
`ifdef RV32I_ENC_JAL_EN
        imm_field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
        class_ok  = 1'b1;
        range_ok  = ~imm[0];
`else
        imm_field = 32'h0000_0000;
        class_ok  = 1'b0;
        range_ok  = 1'b0;
`endif
      end
      default: begin
        imm_field = 32'h0000_0000;
        class_ok  = 1'b0;
        range_ok  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Encodes RV32I instruction descriptors and writes them to consecutive
// instruction-memory words. Define RV32I_ENC_JAL_EN to accept class 5 (JAL).
module rv32i_instr_encoder
  import rv32i_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_class,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic             in_f7b5,
  input  logic [20:0]      in_imm,
  output logic             imem_we,
  input  logic             imem_ready,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  enc_state_e       state_r, state_s;
  logic             we_r, we_s;
  logic [31:0]      wdata_r, wdata_s;
  logic [31:0]      addr_r, addr_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] count_r, count_s;

  logic [31:0] imm_field_s;
  logic        class_ok_s;
  logic        range_ok_s;
  logic [31:0] enc_word_s;
  logic        legal_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        write_done_s;

  rv32i_imm_pack u_imm_pack (
    .cls       (in_class),
    .funct3    (in_funct3),
    .imm       (in_imm),
    .imm_field (imm_field_s),
    .class_ok  (class_ok_s),
    .range_ok  (range_ok_s)
  );

  // Merge register/funct/opcode fields with the scattered immediate.
  always_comb begin
    enc_word_s = 32'h0000_0000;
    case (in_class)
      CLS_LOAD:   enc_word_s = imm_field_s | {12'h000, in_rs1, F3_LW, in_rd, OP_LOAD};
      CLS_STORE:  enc_word_s = imm_field_s | {7'h00, in_rs2, in_rs1, F3_SW, 5'h00, OP_STORE};
      CLS_RTYPE:  enc_word_s = {1'b0, in_f7b5, 5'h00, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
      CLS_ITYPE:  enc_word_s = imm_field_s | {1'b0, in_f7b5 & (in_funct3 == F3_SRX), 10'h000,
                                              in_rs1, in_funct3, in_rd, OP_ITYPE};
      CLS_BRANCH: enc_word_s = imm_field_s | {7'h00, in_rs2, in_rs1, F3_BEQ, 5'h00, OP_BRANCH};
      CLS_JAL:    enc_word_s = imm_field_s | {20'h00000, in_rd, OP_JAL};
      default:    enc_word_s = 32'h0000_0000;
    endcase
  end

  assign legal_s      = class_ok_s & range_ok_s;
  assign in_ready_s   = (state_r == ST_RUN) & ~flush & (~we_r | imem_ready);
  assign accept_s     = in_valid & in_ready_s;
  assign write_done_s = we_r & imem_ready;

  // Next-state and next-output logic; flush overrides any accept or write.
  always_comb begin
    state_s = state_r;
    we_s    = we_r;
    wdata_s = wdata_r;
    addr_s  = addr_r;
    err_s   = err_r;
    count_s = count_r;
    if (flush) begin
      state_s = ST_RUN;
      we_s    = 1'b0;
      addr_s  = BASE_ADDR;
      err_s   = 1'b0;
      count_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (write_done_s) begin
            addr_s  = addr_r + 32'd4;
            count_s = count_r + CNT_W'(1);
            we_s    = 1'b0;
          end else begin
            we_s = we_r;
          end
          if (accept_s) begin
            if (legal_s) begin
              wdata_s = enc_word_s;
              we_s    = 1'b1;
            end else begin
              err_s   = 1'b1;
              we_s    = 1'b0;
              state_s = ST_HALT;
            end
          end else begin
            wdata_s = wdata_r;
          end
        end
        ST_HALT: begin
          we_s = 1'b0;
        end
        default: begin
          state_s = ST_RUN;
          we_s    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      we_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
      addr_r  <= BASE_ADDR;
      err_r   <= 1'b0;
      count_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      we_r    <= we_s;
      wdata_r <= wdata_s;
      addr_r  <= addr_s;
      err_r   <= err_s;
      count_r <= count_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign imem_we    = we_r;
  assign imem_wdata = wdata_r;
  assign imem_addr  = addr_r;
  assign err        = err_r;
  assign count      = count_r;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed cases plus a random
// phase scored against a field-arithmetic reference model.
module tb_rv32i_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int CW = 16;
`ifdef RV32I_ENC_JAL_EN
  localparam int MAXC = 5;
`else
  localparam int MAXC = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready;
  logic [2:0]    in_class, in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic          in_f7b5;
  logic [20:0]   in_imm;
  logic          imem_we, imem_ready, err;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_addr;
  logic [CW-1:0] exp_count;
  bit pend;
  logic [31:0] pword;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .err(err), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int cls, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input int imm);
    in_valid  = 1'b1;
    in_class  = 3'(cls);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_f7b5   = 1'(f7);
    in_imm    = 21'(imm);
  endtask

  function automatic int fld(input int v, input int hi, input int lo);
    return (v >>> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference: instruction word built from the field layout of each format.
  function automatic void ref_enc(input int cls, input int rd, input int rs1, input int rs2,
                                  input int f3, input int f7, input int imm,
                                  output bit ok, output logic [31:0] w);
    int x;
    ok = 1'b0;
    x = 0;
    case (cls)
      0: begin
        ok = (imm >= -2048) && (imm <= 2047);
        x = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      end
      1: begin
        ok = (imm >= -2048) && (imm <= 2047);
        x = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
          | (fld(imm, 4, 0) << 7) | 'h23;
      end
      2: begin
        ok = 1'b1;
        x = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      end
      3: begin
        if (f3 == 5) begin
          ok = (imm >= 0) && (imm <= 31);
          x = (f7 << 30) | (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end else begin
          ok = (imm >= -2048) && (imm <= 2047);
          x = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end
      end
      4: begin
        ok = (imm >= -4096) && (imm <= 4095) && (imm % 2 == 0);
        x = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
          | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 'h63;
      end
`ifdef RV32I_ENC_JAL_EN
      5: begin
        ok = (imm % 2 == 0);
        x = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
          | (fld(imm, 19, 12) << 12) | (rd << 7) | 'h6F;
      end
`endif
      default: ok = 1'b0;
    endcase
    w = 32'(x);
  endfunction

  task automatic gen(output int cls, output int rd, output int rs1, output int rs2,
                     output int f3, output int f7, output int imm);
    cls = int'($urandom_range(0, MAXC));
    rd  = int'($urandom_range(0, 31));
    rs1 = int'($urandom_range(0, 31));
    rs2 = int'($urandom_range(0, 31));
    f3  = int'($urandom_range(0, 7));
    f7  = int'($urandom_range(0, 1));
    case (cls)
      2: imm = int'($urandom_range(0, 1048575)) - 524288;
      3: imm = (f3 == 5) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
      4: imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      5: imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: imm = int'($urandom_range(0, 4095)) - 2048;
    endcase
  endtask

  initial begin
    int c, rd, rs1, rs2, f3, f7, imm;
    bit ok;
    logic [31:0] w;
    logic [31:0] hold_w;

    rst_n = 1'b0; flush = 1'b0; imem_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();

    // LOAD rd=5 rs1=2 imm=8
    drive(0, 5, 2, 0, 0, 0, 8);
    tick();
    in_valid = 1'b0;
    chk("load_we", imem_we, 1);
    chk("load_word", imem_wdata, 32'h0081_2283);
    chk("load_addr", imem_addr, BASE);
    tick();
    chk("load_done_we", imem_we, 0);
    chk("load_count", count, 1);
    chk("load_addr_next", imem_addr, BASE + 32'd4);

    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_addr", imem_addr, BASE);

    // STORE then RTYPE back to back
    drive(1, 0, 2, 5, 0, 0, 12);
    tick();
    drive(2, 3, 1, 2, 0, 1, 0);
    #1;
    chk("b2b_ready", in_ready, 1);
    chk("store_word", imem_wdata, 32'h0051_2623);
    chk("store_addr", imem_addr, BASE);
    tick();
    in_valid = 1'b0;
    chk("rtype_we", imem_we, 1);
    chk("rtype_word", imem_wdata, 32'h4020_81B3);
    chk("rtype_addr", imem_addr, BASE + 32'd4);
    drive(4, 0, 1, 2, 0, 0, -4);
    tick();
    drive(3, 1, 0, 0, 0, 0, -1);
    chk("b2b_count", count, 2);
    chk("branch_word", imem_wdata, 32'hFE20_8EE3);
    tick();
    in_valid = 1'b0;
    chk("itype_word", imem_wdata, 32'hFFF0_0093);
    tick();
    chk("four_count", count, 4);
    chk("four_addr", imem_addr, BASE + 32'd16);

    // Backpressure: word held for 3 cycles
    imem_ready = 1'b0;
    gen(c, rd, rs1, rs2, f3, f7, imm);
    ref_enc(c, rd, rs1, rs2, f3, f7, imm, ok, hold_w);
    drive(c, rd, rs1, rs2, f3, f7, imm);
    tick();
    drive(2, 7, 7, 7, 0, 0, 0);
    chk("stall_word0", imem_wdata, hold_w);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      tick();
      chk("stall_we", imem_we, 1);
      chk("stall_word", imem_wdata, hold_w);
      chk("stall_addr", imem_addr, BASE + 32'd16);
      chk("stall_count", count, 4);
    end
    imem_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("stall_done_we", imem_we, 0);
    chk("stall_done_count", count, 5);

    // Random phase against the transaction model
    exp_addr = BASE + 32'd20;
    exp_count = CW'(5);
    pend = 1'b0;
    pword = 32'h0;
    for (int i = 0; i < 300; i++) begin
      gen(c, rd, rs1, rs2, f3, f7, imm);
      ref_enc(c, rd, rs1, rs2, f3, f7, imm, ok, w);
      drive(c, rd, rs1, rs2, f3, f7, imm);
      in_valid = ($urandom_range(0, 3) != 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_in_ready", in_ready, (!pend || imem_ready) ? 1 : 0);
      ok = in_valid && (!pend || imem_ready);
      tick();
      if (pend && imem_ready) begin
        exp_addr = exp_addr + 32'd4;
        exp_count = exp_count + CW'(1);
        pend = 1'b0;
      end
      if (ok) begin
        pend = 1'b1;
        pword = w;
      end
      chk("rnd_we", imem_we, pend);
      if (pend) chk("rnd_word", imem_wdata, pword);
      chk("rnd_addr", imem_addr, exp_addr);
      chk("rnd_count", count, exp_count);
      chk("rnd_err", err, 0);
    end
    in_valid = 1'b0;
    imem_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Misaligned branch halts
    drive(4, 0, 1, 2, 0, 0, 3);
    tick();
    chk("bra_err", err, 1);
    chk("bra_we", imem_we, 0);
    #1;
    chk("halt_in_ready", in_ready, 0);
    tick();
    chk("halt_we", imem_we, 0);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("unhalt_err", err, 0);
    chk("unhalt_addr", imem_addr, BASE);
    chk("unhalt_count", count, 0);
    chk("unhalt_ready", in_ready, 1);

    // ITYPE immediate out of range
    drive(3, 1, 0, 0, 0, 0, 2048);
    tick();
    in_valid = 1'b0;
    chk("iimm_err", err, 1);
    chk("iimm_we", imem_we, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Illegal class 6
    drive(6, 1, 0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("cls6_err", err, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Class 5
    drive(5, 1, 0, 0, 0, 0, 2048);
    tick();
    in_valid = 1'b0;
`ifdef RV32I_ENC_JAL_EN
    chk("jal_we", imem_we, 1);
    chk("jal_word", imem_wdata, 32'h0010_00EF);
`else
    chk("jal_err", err, 1);
    chk("jal_we", imem_we, 0);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Flush wins over a pending write and a simultaneous accept
    drive(0, 5, 2, 0, 0, 0, 8);
    tick();
    flush = 1'b1;
    #1;
    chk("fb_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fb_we", imem_we, 0);
    chk("fb_count", count, 0);
    chk("fb_addr", imem_addr, BASE);

    // Asynchronous reset drops a pending word
    drive(0, 5, 2, 0, 0, 0, 8);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_we", imem_we, 0);
    chk("arst_wdata", imem_wdata, 0);
    chk("arst_count", count, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
